// File: rtl/board_game_pkg.sv
// Shared types for the N x N line-completion game controller: cell codes,
// winner codes and the controller FSM state encoding.
package board_game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        CHECK = 2'b10,
        OVER  = 2'b11
    } state_t;

endpackage

// File: rtl/board_line_check.sv
// Combinational line test: is line line_idx (rows, then columns, then main
// diagonal, then anti-diagonal) fully owned by the given player code?
module board_line_check
    import board_game_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int LINES   = 2 * BOARD_N + 2,
    parameter int LINE_W  = $clog2(2 * BOARD_N + 2)
) (
    input  logic [2*BOARD_N*BOARD_N-1:0] board,
    input  logic [LINE_W-1:0]            line_idx,
    input  logic [1:0]                   player,
    output logic                         line_won
);

    logic [LINES-1:0] won_vec;

    function automatic int cell_of(input int line, input int k);
        if (line < BOARD_N)          return line * BOARD_N + k;
        else if (line < 2 * BOARD_N) return k * BOARD_N + (line - BOARD_N);
        else if (line == 2 * BOARD_N) return k * (BOARD_N + 1);
        else                         return k * BOARD_N + (BOARD_N - 1 - k);
    endfunction

    // Every line is evaluated in parallel from constant cell indices; the scan
    // index only selects which result is reported this cycle.
    always_comb begin
        won_vec = '1;
        for (int l = 0; l < LINES; l++) begin
            for (int k = 0; k < BOARD_N; k++) begin
                if (board[2*cell_of(l, k) +: 2] != player) won_vec[l] = 1'b0;
            end
        end
    end

    assign line_won = (player != EMPTY) && won_vec[line_idx];

endmodule

// File: rtl/board_game_ctrl.sv
// N x N line-completion game controller: board, cursor, turn ownership,
// sequential one-line-per-cycle win/draw scan and optional turn timeout.
module board_game_ctrl
    import board_game_pkg::*;
#(
    parameter int BOARD_N      = 3,
    parameter int TURN_TIMEOUT = 0,
    parameter int CUR_W        = $clog2(BOARD_N * BOARD_N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_pulse,
    input  logic             move_pulse,
    input  logic             assign_pulse,
    input  logic [CUR_W-1:0] rd_idx,
    output logic [1:0]       rd_owner,
    output logic [CUR_W-1:0] cursor_idx,
    output logic             player_turn,
    output logic             busy,
    output logic             reject,
    output logic             timeout,
    output logic [1:0]       winner,
    output logic             game_over
);

    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int LINES  = 2 * BOARD_N + 2;
    localparam int LINE_W = $clog2(LINES);
    localparam int OCC_W  = $clog2(CELLS + 1);
    localparam int TMR_W  = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

    state_t              state;
    logic [2*CELLS-1:0]  board;
    logic [LINE_W-1:0]   scan_idx;
    logic [OCC_W-1:0]    occ_cnt;
    logic [TMR_W-1:0]    timer;
    logic [1:0]          mover;
    logic [1:0]          cur_cell;
    logic                assign_ok;
    logic                new_game;
    logic                line_won;

    // Inputs are single-cycle pulses with no back-pressure: a pulse is acted on
    // in the cycle it is high or lost; everything arriving while busy is dropped.
    assign mover     = player_turn ? W_P2 : W_P1;
    assign cur_cell  = board[{cursor_idx, 1'b0} +: 2];
    assign assign_ok = assign_pulse && (cur_cell == EMPTY);
    assign new_game  = start_pulse && (state != CHECK);
    assign rd_owner  = ({1'b0, rd_idx} < (CUR_W + 1)'(CELLS)) ? board[{rd_idx, 1'b0} +: 2] : 2'b00;

    board_line_check #(
        .BOARD_N (BOARD_N),
        .LINES   (LINES),
        .LINE_W  (LINE_W)
    ) u_line_check (
        .board    (board),
        .line_idx (scan_idx),
        .player   (mover),
        .line_won (line_won)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            board       <= '0;
            cursor_idx  <= '0;
            player_turn <= 1'b0;
            scan_idx    <= '0;
            occ_cnt     <= '0;
            timer       <= '0;
            winner      <= W_NONE;
            game_over   <= 1'b0;
            busy        <= 1'b0;
            reject      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            reject  <= 1'b0;
            timeout <= 1'b0;
            if (new_game) begin
                state       <= PLAY;
                board       <= '0;
                cursor_idx  <= '0;
                player_turn <= 1'b0;
                occ_cnt     <= '0;
                timer       <= '0;
                winner      <= W_NONE;
                game_over   <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (move_pulse)
                            cursor_idx <= (cursor_idx == CUR_W'(CELLS - 1)) ? '0 : cursor_idx + 1'b1;
                        if (assign_ok) begin
                            board[{cursor_idx, 1'b0} +: 2] <= mover;
                            occ_cnt  <= occ_cnt + 1'b1;
                            timer    <= '0;
                            scan_idx <= '0;
                            state    <= CHECK;
                            busy     <= 1'b1;
                        end else begin
                            if (assign_pulse) reject <= 1'b1;
                            // A rejected assign does not stop the clock on the turn.
                            if (TURN_TIMEOUT > 0 && timer == TMR_LAST) begin
                                player_turn <= ~player_turn;
                                timeout     <= 1'b1;
                                timer       <= '0;
                            end else if (TURN_TIMEOUT > 0) begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (line_won) begin
                            state     <= OVER;
                            winner    <= mover;
                            game_over <= 1'b1;
                            busy      <= 1'b0;
                        end else if (scan_idx == LINE_W'(LINES - 1)) begin
                            busy <= 1'b0;
                            if (occ_cnt == OCC_W'(CELLS)) begin
                                state     <= OVER;
                                winner    <= W_DRAW;
                                game_over <= 1'b1;
                            end else begin
                                state       <= PLAY;
                                player_turn <= ~player_turn;
                                timer       <= '0;
                            end
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/board_game_ctrl.md
Name: board_game_ctrl

Overview:
Parametrised N x N line-completion game controller. It succeeds the fixed 3x3 tic-tac-toe core and generalises it to BOARD_N. It holds board state, the cursor and turn ownership. It runs a sequential win/draw scan, one line per cycle, and applies an optional per-turn timeout. It sits between the debounced button pulses and the VGA sprite/screen logic, which reads cells through a combinational read port.

Parameters:
BOARD_N, 3, board side length; legal range 3..8. A win is a complete row, column or diagonal of BOARD_N cells.
TURN_TIMEOUT, 0, clock cycles allowed per turn before the turn passes to the other player; 0 disables the timeout.
CUR_W, $clog2(BOARD_N*BOARD_N), cursor index width; derived, must not be overridden.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start_pulse  in  1  one-cycle pulse; starts a new game
move_pulse  in  1  one-cycle pulse; advances the cursor
assign_pulse  in  1  one-cycle pulse; claims the cursor cell for the current player
rd_idx  in  CUR_W  cell index for the renderer (row*BOARD_N+col)
rd_owner  out  2  owner of cell rd_idx, combinational
cursor_idx  out  CUR_W  current cursor cell
player_turn  out  1  0 = player1, 1 = player2
busy  out  1  high during the CHECK state
reject  out  1  one-cycle pulse: assign_pulse hit an occupied cell
timeout  out  1  one-cycle pulse: turn forfeited by timeout
winner  out  2  00 none, 01 player1, 10 player2, 11 draw
game_over  out  1  high in the OVER state

Behaviour:
- Cell encoding: 00 empty, 01 player1, 10 player2. Encoding 11 is never written.
- Reset (reset==0 at a clock edge) puts the block in IDLE:
  - all cells 00, cursor_idx 0, player_turn 0;
  - winner 00, game_over 0, busy 0, reject 0, timeout 0;
  - turn timer 0.
- Reset has priority over every other input in every state, including mid-CHECK.
- FSM states: IDLE, PLAY, CHECK, OVER.
- IDLE:
  - start_pulse -> PLAY on the next edge, with the board cleared, cursor 0 and player_turn 0.
  - move_pulse and assign_pulse are ignored.
- PLAY:
  - move_pulse: cursor_idx <= (cursor_idx == N*N-1) ? 0 : cursor_idx+1. Occupied cells are not skipped.
  - assign_pulse on an empty cell:
    - write the player code on the next edge;
    - clear the turn timer;
    - go to CHECK with scan index 0.
  - assign_pulse on an occupied cell: reject=1 for one cycle; no state change.
  - assign_pulse and move_pulse in the same cycle: assign applies to the pre-move cursor; the cursor still advances.
  - start_pulse in PLAY restarts the game exactly as from IDLE. It has priority over move_pulse and assign_pulse.
  - Timeout, when TURN_TIMEOUT > 0:
    - the timer counts every PLAY cycle;
    - when it reaches TURN_TIMEOUT-1 with no accepted assign that cycle: toggle player_turn, timeout=1 for one cycle, timer <= 0.
    - An accepted assign in the same cycle wins; no timeout is raised.
- CHECK (busy=1):
  - Scans 2*BOARD_N+2 lines, one per cycle: rows 0..N-1, then columns 0..N-1, then the main diagonal, then the anti-diagonal.
  - A line is won when all N cells equal the code of the player who just moved.
  - On the first winning line: go to OVER; winner <= that player's code.
  - If the scan completes with no win and the occupied count == N*N: go to OVER; winner <= 11.
  - Otherwise: return to PLAY, toggle player_turn, timer 0.
  - Latency from the assign_pulse cycle to PLAY/OVER is at most 2N+3 cycles. N=3 gives 9.
  - All pulses are ignored and dropped in CHECK, including start_pulse.
- OVER:
  - game_over=1; the board is frozen; winner is held.
  - start_pulse -> new game as in IDLE; winner <= 00.
- Occupied count: register of width $clog2(N*N+1). Increments on each accepted write; cleared on new game and reset.
- rd_owner = cell[rd_idx]. rd_idx >= N*N returns 00.

Decomposition:
- Package board_game_pkg:
  - cell_t enum (EMPTY, P1, P2);
  - winner codes (W_NONE, W_P1, W_P2, W_DRAW);
  - state_t enum (IDLE, PLAY, CHECK, OVER).
- Sub-module board_line_check: combinational. Inputs are the flat board vector, the line index and the player code. Output is line_won. It owns the row/column/diagonal index generation.
- The board register array, cursor, timer and FSM stay in the top module.

Test Plan:
1. Reset, then start_pulse, then P1 assigns at cursor 0 -> cell0=01 and busy=1 for 8 cycles. Then PLAY with player_turn=1 and rd_owner(0)=01.
2. Row win, N=3: P1 claims cells 0,1,2 and P2 claims 3,4 in interleaved order -> after P1's third claim, winner=01 and game_over=1. Later move/assign pulses leave the board unchanged.
3. Anti-diagonal win: P2 claims 2,4,6 -> winner=10 on the final line of the scan (scan index 7). Also check N=4 with cells 3,6,9,12.
4. Draw, N=3: fill order 0,1,2,4,3,5,7,6,8 (no line completed) -> winner=11 after the final check.
5. Occupied cell: assign_pulse at a P1 cell -> reject=1 for one cycle; player_turn, board and cursor unchanged. A simultaneous move_pulse still advances the cursor.
6. Timeout: TURN_TIMEOUT=10, no input for 10 cycles -> timeout pulse and player_turn toggles. Then reset low during CHECK -> all outputs return to reset values on the next edge.
